// File: rtl/vc_rr_arb_mux4_if.sv
// Bundle of the arbiter's handshake and message signals.
// master: the environment (drives requests and downstream ready).
// slave:  the arbiter (drives per-requester ready and the buffered output).
interface vc_rr_arb_mux4_if #(
   parameter int p_nbits = 32
);
   logic [3:0]         in_val;
   logic [3:0]         in_rdy;
   logic [p_nbits-1:0] in0_msg;
   logic [p_nbits-1:0] in1_msg;
   logic [p_nbits-1:0] in2_msg;
   logic [p_nbits-1:0] in3_msg;
   logic               out_val;
   logic               out_rdy;
   logic [p_nbits-1:0] out_msg;
   logic [1:0]         out_src;

   modport master (
      output in_val, in0_msg, in1_msg, in2_msg, in3_msg, out_rdy,
      input  in_rdy, out_val, out_msg, out_src
   );

   modport slave (
      input  in_val, in0_msg, in1_msg, in2_msg, in3_msg, out_rdy,
      output in_rdy, out_val, out_msg, out_src
   );
endinterface

// File: rtl/vc_rr_arb_mux4.sv
// vc_rr_arb_mux4: 4-input round-robin arbiter feeding a one-entry output
// buffer. The winner's message and index are registered; out_src can steer
// a downstream 4:1 mux.
//
// Build option: define VC_RR_ARB_MUX4_PIPE_EN to let a draining buffer
// accept a new message in the same cycle (1 msg/cycle, adds a combinational
// out_rdy -> in_rdy path). Default build accepts only into an empty buffer
// (1 msg per 2 cycles, no out_rdy -> in_rdy path).
module vc_rr_arb_mux4 #(
   parameter int p_nbits = 32
) (
   input  logic               clk,
   input  logic               reset,   // synchronous, active low
   vc_rr_arb_mux4_if.slave    bus
);

   logic               full_reg, full_next;
   logic [p_nbits-1:0] msg_reg,  msg_next;
   logic [1:0]         src_reg,  src_next;
   logic [1:0]         ptr_reg,  ptr_next;

   logic [p_nbits-1:0] in_msgs [4];
   logic [3:0]         rot_val;     // in_val rotated so bit 0 is the ptr requester
   logic               grant_val;
   logic [1:0]         grant_off;   // winner's distance from ptr
   logic [1:0]         grant_idx;
   logic               accept_ok;
   logic               in_xfer;
   logic               out_xfer;

   assign in_msgs[0] = bus.in0_msg;
   assign in_msgs[1] = bus.in1_msg;
   assign in_msgs[2] = bus.in2_msg;
   assign in_msgs[3] = bus.in3_msg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rot
         assign rot_val[gi] = bus.in_val[ptr_reg + 2'(gi)];
      end
   endgenerate

   // Fixed-priority pick on the rotated vector: lowest offset from ptr wins.
   always_comb begin
      grant_val = |rot_val;
      grant_off = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (rot_val[k]) grant_off = 2'(k);
      end
   end

   assign grant_idx = ptr_reg + grant_off;

`ifdef VC_RR_ARB_MUX4_PIPE_EN
   assign accept_ok = !full_reg || bus.out_rdy;
`else
   assign accept_ok = !full_reg;
`endif

   // Ready goes only to the winner, and never while reset is held.
   assign in_xfer  = reset && grant_val && accept_ok;
   assign out_xfer = full_reg && bus.out_rdy;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_rdy
         assign bus.in_rdy[gi] = in_xfer && (grant_idx == 2'(gi));
      end
   endgenerate

   // Buffer/pointer update: a load wins over a drain, so a simultaneous
   // drain and load keeps the buffer full with the new message.
   always_comb begin
      full_next = full_reg;
      msg_next  = msg_reg;
      src_next  = src_reg;
      ptr_next  = ptr_reg;
      if (in_xfer) begin
         full_next = 1'b1;
         msg_next  = in_msgs[grant_idx];
         src_next  = grant_idx;
         ptr_next  = grant_idx + 2'd1;
      end else if (out_xfer) begin
         full_next = 1'b0;
      end
   end

   // State registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         full_reg <= 1'b0;
         msg_reg  <= '0;
         src_reg  <= 2'd0;
         ptr_reg  <= 2'd0;
      end else begin
         full_reg <= full_next;
         msg_reg  <= msg_next;
         src_reg  <= src_next;
         ptr_reg  <= ptr_next;
      end
   end

   assign bus.out_val = full_reg;
   assign bus.out_msg = msg_reg;
   assign bus.out_src = src_reg;

endmodule

// File: tb/tb_vc_rr_arb_mux4.sv
// Testbench for vc_rr_arb_mux4. Directed scenarios against fixed expected
// values, then randomized traffic against a behavioural model of the
// buffer, a message scoreboard and a fairness bound.
// Honours VC_RR_ARB_MUX4_PIPE_EN the same way the design does.
module tb_vc_rr_arb_mux4;

`ifdef VC_RR_ARB_MUX4_PIPE_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif

   logic clk;
   logic reset;

   vc_rr_arb_mux4_if #(.p_nbits(32)) bus ();

   vc_rr_arb_mux4 #(.p_nbits(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] msg_in [4];

   // model state: contents of the one-entry buffer and the priority pointer
   bit          m_full = 1'b0;
   logic [31:0] m_msg  = '0;
   logic [1:0]  m_src  = '0;
   int          m_ptr  = 0;

   // expected DUT outputs for the cycle just driven
   logic [3:0]  exp_rdy;
   logic        exp_val;
   logic [1:0]  exp_src;
   logic [31:0] exp_msg;

   // Drive one cycle of inputs at the falling edge, let outputs settle,
   // derive expectations from the model, then advance the model across
   // the coming rising edge.
   task automatic step(input logic rst_n, input logic [3:0] v, input logic ordy);
      int  g;
      bit  acc;
      @(negedge clk);
      reset       = rst_n;
      bus.in_val  = v;
      bus.out_rdy = ordy;
      bus.in0_msg = msg_in[0];
      bus.in1_msg = msg_in[1];
      bus.in2_msg = msg_in[2];
      bus.in3_msg = msg_in[3];
      #1;
      exp_val = m_full;
      exp_msg = m_msg;
      exp_src = m_src;
      exp_rdy = 4'b0000;
      g = -1;
      if (rst_n) begin
         for (int k = 0; k < 4; k++) begin
            if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
         end
      end
      acc = PIPE ? (!m_full || ordy) : !m_full;
      if (g >= 0 && acc) exp_rdy[g] = 1'b1;
      if (!rst_n) begin
         m_full = 1'b0; m_msg = '0; m_src = '0; m_ptr = 0;
      end else if (g >= 0 && acc) begin
         m_full = 1'b1; m_msg = msg_in[g]; m_src = 2'(g); m_ptr = (g + 1) % 4;
      end else if (m_full && ordy) begin
         m_full = 1'b0;
      end
   endtask

   task automatic drain();
      step(1'b1, 4'b0000, 1'b1);
      step(1'b1, 4'b0000, 1'b1);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         step(1'b0, 4'b1111, 1'b1);
         n_cmp++;
         if ({bus.in_rdy, bus.out_val, bus.out_src, bus.out_msg} !== 39'd0) begin
            n_bad++;
            $display("FAIL reset[%0d]: got rdy=%b val=%b src=%0d msg=%h, need all zero",
                     c, bus.in_rdy, bus.out_val, bus.out_src, bus.out_msg);
         end
      end
   endtask

   task automatic test_round_robin();
      int seen = 0;
      int last = PIPE ? 5 : 9;
      for (int i = 0; i < 4; i++) msg_in[i] = 32'hA0 + 32'(i);
      for (int c = 0; c <= last; c++) begin
         step(1'b1, 4'b1111, 1'b1);
         if (c == 0) begin
            n_cmp++;
            if (bus.in_rdy !== 4'b0001) begin
               n_bad++;
               $display("FAIL rr_first_grant: got in_rdy=%b need 0001", bus.in_rdy);
            end
         end
         n_cmp++;
         if (bus.out_val !== (PIPE ? (c >= 1) : (c % 2 == 1))) begin
            n_bad++;
            $display("FAIL rr_out_val[c%0d]: got %b", c, bus.out_val);
         end
         if (bus.out_val === 1'b1 && seen < 5) begin
            n_cmp++;
            if (bus.out_src !== 2'(seen % 4) || bus.out_msg !== 32'hA0 + 32'(seen % 4)) begin
               n_bad++;
               $display("FAIL rr_seq[%0d]: got src=%0d msg=%h need src=%0d msg=%h",
                        seen, bus.out_src, bus.out_msg, seen % 4, 32'hA0 + 32'(seen % 4));
            end
            seen++;
         end
      end
      n_cmp++;
      if (seen != 5) begin
         n_bad++;
         $display("FAIL rr_count: got %0d outputs need 5", seen);
      end
   endtask

   task automatic test_ptr_wrap();
      logic [3:0] got;
      drain();
      step(1'b1, 4'b0100, 1'b1);
      n_cmp++;
      if (bus.in_rdy !== 4'b0100) begin
         n_bad++;
         $display("FAIL wrap_grant2: got in_rdy=%b need 0100", bus.in_rdy);
      end
      got = 4'b0000;
      for (int c = 0; c < 3 && got == 4'b0000; c++) begin
         step(1'b1, 4'b0011, 1'b1);
         got = bus.in_rdy;
      end
      n_cmp++;
      if (got !== 4'b0001) begin
         n_bad++;
         $display("FAIL wrap_grant0: got in_rdy=%b need 0001", got);
      end
      got = 4'b0000;
      for (int c = 0; c < 3 && got == 4'b0000; c++) begin
         step(1'b1, 4'b0011, 1'b1);
         got = bus.in_rdy;
      end
      n_cmp++;
      if (got !== 4'b0010) begin
         n_bad++;
         $display("FAIL wrap_grant1: got in_rdy=%b need 0010", got);
      end
   endtask

   task automatic test_backpressure();
      drain();
      msg_in[2] = 32'h55;
      step(1'b1, 4'b0100, 1'b0);
      n_cmp++;
      if (bus.in_rdy !== 4'b0100) begin
         n_bad++;
         $display("FAIL bp_load: got in_rdy=%b need 0100", bus.in_rdy);
      end
      for (int c = 0; c < 5; c++) begin
         step(1'b1, 4'b1111, 1'b0);
         n_cmp++;
         if ({bus.in_rdy, bus.out_val, bus.out_src, bus.out_msg} !== {4'b0000, 1'b1, 2'd2, 32'h55}) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: got rdy=%b val=%b src=%0d msg=%h need rdy=0000 val=1 src=2 msg=55",
                     c, bus.in_rdy, bus.out_val, bus.out_src, bus.out_msg);
         end
      end
      drain();
   endtask

   task automatic test_simultaneous();
      drain();
      msg_in[0] = 32'h11;
      msg_in[2] = 32'h22;
      step(1'b1, 4'b0001, 1'b0);
      n_cmp++;
      if (bus.in_rdy !== 4'b0001) begin
         n_bad++;
         $display("FAIL sim_load: got in_rdy=%b need 0001", bus.in_rdy);
      end
      step(1'b1, 4'b0100, 1'b1);
      n_cmp++;
      if ({bus.in_rdy, bus.out_val, bus.out_msg} !== {(PIPE ? 4'b0100 : 4'b0000), 1'b1, 32'h11}) begin
         n_bad++;
         $display("FAIL sim_both: got rdy=%b val=%b msg=%h need rdy=%b val=1 msg=11",
                  bus.in_rdy, bus.out_val, bus.out_msg, PIPE ? 4'b0100 : 4'b0000);
      end
      if (!PIPE) begin
         step(1'b1, 4'b0100, 1'b1);
         n_cmp++;
         if ({bus.in_rdy, bus.out_val} !== {4'b0100, 1'b0}) begin
            n_bad++;
            $display("FAIL sim_bubble: got rdy=%b val=%b need rdy=0100 val=0",
                     bus.in_rdy, bus.out_val);
         end
      end
      step(1'b1, 4'b0000, 1'b0);
      n_cmp++;
      if ({bus.out_val, bus.out_src, bus.out_msg} !== {1'b1, 2'd2, 32'h22}) begin
         n_bad++;
         $display("FAIL sim_new: got val=%b src=%0d msg=%h need val=1 src=2 msg=22",
                  bus.out_val, bus.out_src, bus.out_msg);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      drain();
      msg_in[0] = 32'hC0;
      msg_in[1] = 32'h77;
      step(1'b1, 4'b0010, 1'b0);
      n_cmp++;
      if (bus.in_rdy !== 4'b0010) begin
         n_bad++;
         $display("FAIL rm_load: got in_rdy=%b need 0010", bus.in_rdy);
      end
      step(1'b0, 4'b1111, 1'b1);
      n_cmp++;
      if ({bus.in_rdy, bus.out_val, bus.out_msg} !== {4'b0000, 1'b1, 32'h77}) begin
         n_bad++;
         $display("FAIL rm_in_reset: got rdy=%b val=%b msg=%h need rdy=0000 val=1 msg=77",
                  bus.in_rdy, bus.out_val, bus.out_msg);
      end
      step(1'b1, 4'b1111, 1'b1);
      n_cmp++;
      if ({bus.in_rdy, bus.out_val} !== {4'b0001, 1'b0}) begin
         n_bad++;
         $display("FAIL rm_after: got rdy=%b val=%b need rdy=0001 val=0",
                  bus.in_rdy, bus.out_val);
      end
      step(1'b1, 4'b0000, 1'b1);
      n_cmp++;
      if ({bus.out_val, bus.out_src, bus.out_msg} !== {1'b1, 2'd0, 32'hC0}) begin
         n_bad++;
         $display("FAIL rm_restart: got val=%b src=%0d msg=%h need val=1 src=0 msg=c0",
                  bus.out_val, bus.out_src, bus.out_msg);
      end
      drain();
   endtask

   task automatic test_random();
      logic [33:0] sb [$];
      logic [33:0] e;
      int          wait_cnt [4];
      logic        rst_n;
      logic [3:0]  v;
      logic        ordy;
      logic [3:0]  in_x;
      bit          starved;
      drain();
      foreach (wait_cnt[i]) wait_cnt[i] = 0;
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         v     = 4'($urandom);
         ordy  = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 4; i++) msg_in[i] = $urandom;
         step(rst_n, v, ordy);
         n_cmp++;
         if ({bus.in_rdy, bus.out_val, bus.out_src, bus.out_msg} !== {exp_rdy, exp_val, exp_src, exp_msg}) begin
            n_bad++;
            $display("FAIL rand_model[c%0d]: got rdy=%b val=%b src=%0d msg=%h need rdy=%b val=%b src=%0d msg=%h",
                     c, bus.in_rdy, bus.out_val, bus.out_src, bus.out_msg,
                     exp_rdy, exp_val, exp_src, exp_msg);
         end
         if (!rst_n) begin
            sb.delete();
            foreach (wait_cnt[i]) wait_cnt[i] = 0;
         end else begin
            if (bus.out_val && ordy) begin
               $display("xfer c%0d src=%0d msg=%h", c, bus.out_src, bus.out_msg);
               n_cmp++;
               if (sb.size() == 0) begin
                  n_bad++;
                  $display("FAIL rand_sb_extra[c%0d]: got src=%0d msg=%h need no output",
                           c, bus.out_src, bus.out_msg);
               end else begin
                  e = sb.pop_front();
                  if ({bus.out_src, bus.out_msg} !== e) begin
                     n_bad++;
                     $display("FAIL rand_sb[c%0d]: got src=%0d msg=%h need src=%0d msg=%h",
                              c, bus.out_src, bus.out_msg, e[33:32], e[31:0]);
                  end
               end
            end
            in_x = v & bus.in_rdy;
            for (int i = 0; i < 4; i++) begin
               if (in_x[i]) sb.push_back({2'(i), msg_in[i]});
               if (!v[i] || in_x[i]) wait_cnt[i] = 0;
               else if (in_x != 4'b0000) wait_cnt[i]++;
            end
            starved = 1'b0;
            foreach (wait_cnt[i]) if (wait_cnt[i] > 3) starved = 1'b1;
            n_cmp++;
            if (starved) begin
               n_bad++;
               $display("FAIL rand_fair[c%0d]: got waits %0d/%0d/%0d/%0d need each <= 3",
                        c, wait_cnt[0], wait_cnt[1], wait_cnt[2], wait_cnt[3]);
               foreach (wait_cnt[i]) wait_cnt[i] = 0;
            end
         end
      end
   endtask

   initial begin
      reset       = 1'b0;
      bus.in_val  = 4'b0000;
      bus.out_rdy = 1'b0;
      bus.in0_msg = '0;
      bus.in1_msg = '0;
      bus.in2_msg = '0;
      bus.in3_msg = '0;
      for (int i = 0; i < 4; i++) msg_in[i] = '0;
      test_reset();
      test_round_robin();
      test_ptr_wrap();
      test_backpressure();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vc_rr_arb_mux4.md
VC_RR_ARB_MUX4 -- requirements
Module: vc_rr_arb_mux4

Interface
REQ-001 SHALL have parameter p_nbits, default 32, message width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-004 SHALL have port in_val  input  4  per-requester valid, bit i = requester i.
REQ-005 SHALL have port in_rdy  output  4  per-requester ready, bit i = requester i.
REQ-006 SHALL have ports in0_msg, in1_msg, in2_msg, in3_msg  input  p_nbits each  requester messages.
REQ-007 SHALL have port out_val  output  1  buffered message valid.
REQ-008 SHALL have port out_rdy  input  1  downstream ready.
REQ-009 SHALL have port out_msg  output  p_nbits  buffered message.
REQ-010 SHALL have port out_src  output  2  index of requester whose message is buffered; drives a downstream 4-input mux select.

Function
REQ-011 SHALL hold one-entry output buffer (full flag, msg, src); out_val = full, out_msg = buffered msg, out_src = buffered src, all driven from registers.
REQ-012 SHALL keep 2-bit priority pointer ptr; requester ptr has highest priority, then ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 SHALL compute grant g = first i in that order with in_val[i]=1; no grant when in_val=4'b0000.
REQ-014 SHALL assert in_rdy[g] = accept_ok only for granted requester; all other in_rdy bits 0; in_rdy SHALL NOT depend on any msg input.
REQ-015 SHALL define input transfer as in_val[g] & in_rdy[g]; at most one input transfer per cycle.
REQ-016 SHALL, on input transfer, load buffer msg <= in<g>_msg, src <= g, full <= 1, ptr <= g+1 mod 4 (wrap 3 -> 0).
REQ-017 SHALL leave ptr unchanged in any cycle without input transfer.
REQ-018 SHALL define output transfer as out_val & out_rdy; on output transfer with no input transfer, full <= 0 and msg/src retain value.
REQ-019 SHALL, on simultaneous output and input transfer, keep full=1 and load new msg/src (no bubble).
REQ-020 SHALL hold out_msg/out_src stable while out_val=1 and out_rdy=0.
REQ-021 SHALL give latency of exactly 1 cycle from input transfer to out_val=1 with that message.
REQ-022 SHALL never drop or duplicate a message; an ungranted requester holding in_val=1 is granted within 4 input transfers.

Reset
REQ-023 SHALL, when reset=0 at a rising edge, set full=0, ptr=0, buffered msg=0, src=0; out_val=0, out_msg=0, out_src=0 the following cycle.
REQ-024 SHALL force in_rdy=4'b0000 while reset=0.
REQ-025 SHALL discard a buffered message on reset mid-operation; no transfer occurs in a reset cycle.

Configuration
REQ-026 SHALL use macro VC_RR_ARB_MUX4_PIPE_EN.
REQ-027 SHALL, with VC_RR_ARB_MUX4_PIPE_EN defined, set accept_ok = !full | out_rdy (full throughput, 1 msg/cycle, combinational out_rdy -> in_rdy path).
REQ-028 SHALL, without VC_RR_ARB_MUX4_PIPE_EN, set accept_ok = !full (no out_rdy -> in_rdy path; max throughput 1 msg per 2 cycles; REQ-019 unreachable).

Verification
REQ-029 SHALL cover reset: hold reset=0 two cycles with in_val=4'b1111 -> in_rdy=4'b0000, out_val=0, out_msg=0, out_src=0.
REQ-030 SHALL cover round-robin: in_val=4'b1111 constant, out_rdy=1, msgs 0xA0..0xA3, PIPE_EN -> out_src sequence 0,1,2,3,0 on consecutive cycles, out_msg 0xA0,0xA1,0xA2,0xA3,0xA0.
REQ-031 SHALL cover pointer wrap: ptr=3 after grant to 2, in_val=4'b0011 -> grant 0 (in_rdy=4'b0001), then ptr=1, next grant 1.
REQ-032 SHALL cover backpressure: buffer holds 0x55 src 2, out_rdy=0 five cycles -> out_val=1, out_msg=0x55, out_src=2 stable, in_rdy=4'b0000.
REQ-033 SHALL cover simultaneous transfer: full with 0x11, out_rdy=1, in_val=4'b0100 msg 0x22, PIPE_EN -> next cycle out_msg=0x22, out_src=2, out_val=1; without PIPE_EN in_rdy=0 that cycle, out_val=0 next cycle, 0x22 appears one cycle later.
REQ-034 SHALL cover reset mid-operation: full with 0x77, reset=0 one cycle -> out_val=0 next cycle, 0x77 never transferred, ptr=0 (grant order restarts at 0).
